// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display path:
// active-high glyph table, segment bit positions and a width helper.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // {g,f,e,d,c,b,a}, 1 = lit; codes 10..15 render as A,b,C,d,E,F
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_driver_n_seg7_hex_lut.sv
// Combinational hex digit to active-high 7-segment pattern.
module seg7_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  assign pattern = SEG_PAT[code];

endmodule

// File: rtl/seg_scan_driver_n.sv
// Multiplexed NUM_DIG-digit 7-segment scanner with per-frame input snapshot,
// leading-zero blanking, PWM brightness, guard interval and output polarity.
module seg_scan_driver_n
  import seg_pkg::*;
#(
  parameter int NUM_DIG     = 6,
  parameter int SCAN_LOG2   = 16,
  parameter int BR_W        = 3,
  parameter int GUARD       = 64,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   i_digits,
  input  logic [NUM_DIG-1:0]     i_dp,
  input  logic                   i_blank_lz,
  input  logic [BR_W-1:0]        i_bright,
  input  logic                   i_en,
  output logic [NUM_DIG-1:0]     o_seg_sel,
  output logic [7:0]             o_seg,
  output logic                   o_frame_tick
);

  localparam int                   IDX_W   = clog2(NUM_DIG);
  localparam logic [SCAN_LOG2-1:0] CNT_MAX = '1;
  localparam logic [SCAN_LOG2-1:0] GUARD_C = SCAN_LOG2'(GUARD);
  localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0]   SEL_INV = {NUM_DIG{SEL_ACT_LOW}};
  localparam logic [7:0]           SEG_INV = {8{SEG_ACT_LOW}};

  logic [SCAN_LOG2-1:0] cnt;
  logic [IDX_W-1:0]     idx;
  logic                 slot_end;
  logic                 frame_end;

  logic [4*NUM_DIG-1:0] snap_digits;
  logic [NUM_DIG-1:0]   snap_dp;
  logic                 snap_blank;

  logic [3:0]           cur_code;
  logic [6:0]           cur_pat;
  logic                 cur_dp;
  logic                 zero_run;
  logic [NUM_DIG-1:0]   blank_mask;
  logic                 on;
  logic [NUM_DIG-1:0]   sel_hi;
  logic [7:0]           seg_hi;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // Latch the inputs once per frame so every digit shows the same value.
  // NOTE: these are plain registers, not a RAM, so they take the reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= 1'b0;
    end else if (frame_end) begin
      snap_digits <= i_digits;
      snap_dp     <= i_dp;
      snap_blank  <= i_blank_lz;
    end
  end

  assign cur_code = snap_digits[{idx, 2'b00} +: 4];
  assign cur_dp   = snap_dp[idx];

  seg7_hex_lut u_lut (
    .code    (cur_code),
    .pattern (cur_pat)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    zero_run   = snap_blank;
    blank_mask = '0;
    for (int k = NUM_DIG - 1; k > 0; k--) begin
      zero_run      = zero_run && (snap_digits[4*k +: 4] == 4'd0) && !snap_dp[k];
      blank_mask[k] = zero_run;
    end
  end

  assign on = i_en && (cnt >= GUARD_C) && (cnt[SCAN_LOG2-1 -: BR_W] <= i_bright);

  always_comb begin
    sel_hi = '0;
    seg_hi = '0;
    if (on) begin
      sel_hi[idx]    = 1'b1;
      seg_hi[SEG_DP] = cur_dp;
      if (!blank_mask[idx]) seg_hi[SEG_G:SEG_A] = cur_pat;
    end
  end

  // Polarity is folded in only here; reset drives the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg_sel    <= SEL_INV;
      o_seg        <= SEG_INV;
      o_frame_tick <= 1'b0;
    end else begin
      o_seg_sel    <= sel_hi ^ SEL_INV;
      o_seg        <= seg_hi ^ SEG_INV;
      o_frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver_n.sv
// Self-checking bench for seg_scan_driver_n: frame-position reference model
// with directed scenarios and randomized input traffic.
module tb_seg_scan_driver_n;

  localparam int ND = 6;
  localparam int SL = 4;
  localparam int BW = 2;
  localparam int GD = 2;
  localparam int SD = 1 << SL;
  localparam int FR = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   i_digits;
  logic [5:0]    i_dp;
  logic          i_blank_lz;
  logic [1:0]    i_bright;
  logic          i_en;
  logic [5:0]    o_seg_sel;
  logic [7:0]    o_seg;
  logic          o_frame_tick;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release, last position, frame snapshot.
  int          n      = 0;
  int          last_p = -1;
  logic [23:0] m_dig  = '0;
  logic [5:0]  m_dp   = '0;
  logic        m_blank = 1'b0;

  logic [6:0] pat [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seg_scan_driver_n #(
    .NUM_DIG     (ND),
    .SCAN_LOG2   (SL),
    .BR_W        (BW),
    .GUARD       (GD),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_digits     (i_digits),
    .i_dp         (i_dp),
    .i_blank_lz   (i_blank_lz),
    .i_bright     (i_bright),
    .i_en         (i_en),
    .o_seg_sel    (o_seg_sel),
    .o_seg        (o_seg),
    .o_frame_tick (o_frame_tick)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (pos=%0d)", tag, obs, exp, last_p);
    end
  endtask

  // One clock: predict outputs from frame position and current inputs, then compare.
  task automatic step();
    int         p, slot, c;
    logic       on, blanked;
    logic [3:0] code;
    logic [5:0] e_sel;
    logic [7:0] e_seg;
    logic       e_tick;
    p       = n % FR;
    slot    = p / SD;
    c       = p % SD;
    on      = i_en && c >= GD && (c >> (SL - BW)) <= int'(i_bright);
    code    = 4'((m_dig >> (4 * slot)) & 24'hF);
    blanked = m_blank && slot != 0 && (m_dig >> (4 * slot)) == 0 && (m_dp >> slot) == 0;
    e_sel   = on ? ~(6'b1 << slot) : 6'h3F;
    e_seg   = on ? ~{m_dp[slot], blanked ? 7'h00 : pat[code]} : 8'hFF;
    e_tick  = (p == FR - 1);
    if (p == FR - 1) begin
      m_dig   = i_digits;
      m_dp    = i_dp;
      m_blank = i_blank_lz;
    end
    @(posedge clk);
    #1;
    n++;
    last_p = p;
    check("sel",  {2'b00, o_seg_sel}, {2'b00, e_sel});
    check("seg",  o_seg, e_seg);
    check("tick", {7'd0, o_frame_tick}, {7'd0, e_tick});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic goto(input int target);
    int k;
    k = 0;
    while (last_p != target && k <= FR) begin
      step();
      k++;
    end
    if (last_p != target) check("goto_timeout", 8'(last_p), 8'(target));
  endtask

  task automatic expect_seg(input string tag, input int slot, input int c, input logic [7:0] exp);
    goto(slot * SD + c);
    check(tag, o_seg, exp);
  endtask

  task automatic model_reset();
    n       = 0;
    last_p  = -1;
    m_dig   = '0;
    m_dp    = '0;
    m_blank = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    i_digits   = 24'h0;
    i_dp       = 6'h0;
    i_blank_lz = 1'b0;
    i_bright   = 2'd3;
    i_en       = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_sel",  {2'b00, o_seg_sel}, 8'h3F);
    check("rst_seg",  o_seg, 8'hFF);
    check("rst_tick", {7'd0, o_frame_tick}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold_seg", o_seg, 8'hFF);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();

    // Scan order and first lit cycle of slot 0
    i_digits = 24'h543210;
    i_dp     = 6'b000100;
    run(3);
    check("first_sel", {2'b00, o_seg_sel}, 8'h3E);
    goto(FR - 1);

    // Decode and decimal point
    expect_seg("dp_slot2", 2, 5, 8'h24);
    expect_seg("dig_slot5", 5, 5, 8'h92);

    // Leading-zero blanking
    i_digits   = 24'h000070;
    i_dp       = 6'h00;
    i_blank_lz = 1'b1;
    goto(FR - 1);
    expect_seg("lz_slot0", 0, 5, 8'hC0);
    expect_seg("lz_slot1", 1, 5, 8'hF8);
    expect_seg("lz_slot3", 3, 5, 8'hFF);
    expect_seg("lz_slot5", 5, 5, 8'hFF);
    i_dp = 6'b001000;
    goto(FR - 1);
    expect_seg("lz_dp_slot2", 2, 5, 8'hC0);
    expect_seg("lz_dp_slot3", 3, 5, 8'h40);

    // Brightness steps
    i_bright = 2'd0;
    goto(FR - 1);
    expect_seg("br0_on",  0, 3, 8'hC0);
    expect_seg("br0_off", 0, 4, 8'hFF);
    goto(FR - 1);
    i_bright = 2'd1;
    expect_seg("br1_on",  0, 7, 8'hC0);
    expect_seg("br1_off", 0, 8, 8'hFF);
    goto(FR - 1);
    i_bright = 2'd3;
    expect_seg("br3_guard", 0, 1, 8'hFF);
    expect_seg("br3_end",   0, 15, 8'hC0);

    // Snapshot coherence across a mid-frame input change
    i_digits   = 24'h111111;
    i_dp       = 6'h00;
    i_blank_lz = 1'b0;
    goto(FR - 1);
    expect_seg("coh_pre", 2, 5, 8'hF9);
    goto(3 * SD);
    i_digits = 24'h222222;
    expect_seg("coh_slot4", 4, 5, 8'hF9);
    expect_seg("coh_slot5", 5, 5, 8'hF9);
    expect_seg("coh_next",  0, 5, 8'hA4);

    // Display disable keeps the scan phase running
    i_en = 1'b0;
    run(40);
    i_en = 1'b1;
    run(FR);

    // Randomized traffic
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FR; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          i_digits   = 24'($urandom);
          i_dp       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
          i_blank_lz = 1'($urandom);
          i_bright   = 2'($urandom);
          i_en       = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 1) == 0) i_digits = i_digits & 24'h000FFF;
        end
        step();
      end
    end

    // Asynchronous reset in slot 4, then restart from slot 0
    i_en     = 1'b1;
    i_bright = 2'd3;
    goto(4 * SD + 6);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sel",  {2'b00, o_seg_sel}, 8'h3F);
    check("midrst_seg",  o_seg, 8'hFF);
    check("midrst_tick", {7'd0, o_frame_tick}, 8'h00);
    @(posedge clk);
    #1;
    check("midrst_hold", {2'b00, o_seg_sel}, 8'h3F);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    run(3);
    check("restart_sel", {2'b00, o_seg_sel}, 8'h3E);
    expect_seg("restart_seg", 0, 5, 8'hC0);
    run(FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
